// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: grid geometry, line-clear FSM states and the
// per-clear scoring table.
package tetris_pkg;

    localparam int ROWS = 22;
    localparam int COLS = 10;

    typedef logic [ROWS-1:0][COLS-1:0] grid_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FINISH
    } line_clear_state_t;

    // Points awarded for one clear, indexed by min(lines, 4)
    localparam int unsigned POINTS [5] = '{0, 40, 100, 300, 1200};

endpackage

// File: rtl/score_acc.sv
// Saturating score accumulator step: adds the points for a clear of
// lines_i rows to score_i, clamping at all-ones instead of wrapping.
module score_acc
    import tetris_pkg::*;
#(
    parameter int SCORE_W = 20
) (
    input  logic [SCORE_W-1:0] score_i,
    input  logic [4:0]         lines_i,
    output logic [SCORE_W-1:0] score_o
);

    logic [2:0]       idx;
    logic [SCORE_W:0] sum;

    always_comb begin
        idx     = (lines_i > 5'd4) ? 3'd4 : lines_i[2:0];
        sum     = {1'b0, score_i} + (SCORE_W+1)'(POINTS[idx]);
        score_o = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    end

endmodule

// File: rtl/line_clear.sv
// Line-clear stage: scans the captured grid bottom-up one row per clock,
// compacting non-full rows downward in place, then publishes the result.
module line_clear #(
    parameter int ROWS    = tetris_pkg::ROWS,
    parameter int COLS    = tetris_pkg::COLS,
    parameter int SCORE_W = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [ROWS-1:0][COLS-1:0] grid_i,
    output logic [ROWS-1:0][COLS-1:0] grid_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [4:0]                lines_o,
    output logic [SCORE_W-1:0]        score_o
);
    import tetris_pkg::*;

    localparam int RW = $clog2(ROWS);

    line_clear_state_t         state, state_nxt;
    logic [ROWS-1:0][COLS-1:0] work, cleared;
    logic [RW-1:0]             rd, wr;
    logic [4:0]                cnt;
    logic [SCORE_W-1:0]        score_nxt;
    logic                      row_full;

    assign row_full = &work[rd];
    assign busy_o   = (state != IDLE);

    // After the scan wr == cnt-1, so rows above it hold stale data
    always_comb begin
        for (int r = 0; r < ROWS; r++)
            cleared[r] = (r < int'(cnt)) ? '0 : work[r];
    end

    score_acc #(.SCORE_W(SCORE_W)) u_score_acc (
        .score_i (score_o),
        .lines_i (cnt),
        .score_o (score_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = SCAN;
            SCAN:    if (rd == '0) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work    <= '0;
            rd      <= '0;
            wr      <= '0;
            cnt     <= '0;
            grid_o  <= '0;
            lines_o <= '0;
            score_o <= '0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        work <= grid_i;
                        rd   <= RW'(ROWS-1);
                        wr   <= RW'(ROWS-1);
                        cnt  <= '0;
                    end
                end
                SCAN: begin
                    // wr >= rd, so the copy never clobbers an unread row
                    if (row_full) begin
                        cnt <= cnt + 5'd1;
                    end else begin
                        work[wr] <= work[rd];
                        wr       <= wr - RW'(1);
                    end
                    rd <= rd - RW'(1);
                end
                FINISH: begin
                    grid_o  <= cleared;
                    lines_o <= cnt;
                    score_o <= score_nxt;
                    done_o  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear.sv
// Randomized scoreboard bench for line_clear: a queue-based row filter
// model predicts each result, a monitor compares on every done_o pulse.
module tb_line_clear;
    import tetris_pkg::*;

    localparam int SW = 20;
    localparam longint SMAX = (longint'(1) << SW) - 1;

    typedef struct {
        grid_t grid;
        int    lines;
        longint score;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    grid_t             grid_i = '0;
    grid_t             grid_o;
    logic              busy_o, done_o;
    logic [4:0]        lines_o;
    logic [SW-1:0]     score_o;

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     done_seen = 0;
    int     ops_done = 0;
    longint model_score = 0;

    line_clear #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .grid_i  (grid_i),
        .grid_o  (grid_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .lines_o (lines_o),
        .score_o (score_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic longint pts(input int n);
        case (n)
            0:       return 0;
            1:       return 40;
            2:       return 100;
            3:       return 300;
            default: return 1200;
        endcase
    endfunction

    // Keep the non-full rows in top-to-bottom order, stack them at the bottom
    function automatic void model(input grid_t g, output grid_t o, output int lines);
        grid_t kept[$];
        grid_t row;
        int base;
        kept.delete();
        for (int i = 0; i < ROWS; i++) begin
            row = '0;
            row[0] = g[i];
            if (g[i] != {COLS{1'b1}}) kept.push_back(row);
        end
        lines = ROWS - kept.size();
        base  = ROWS - kept.size();
        o = '0;
        for (int i = 0; i < ROWS; i++)
            if (i >= base) o[i] = kept[i-base][0];
    endfunction

    // Monitor: every done_o pulse must match the oldest outstanding prediction
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            exp_t e;
            done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("grid_o", grid_o, e.grid);
                check("lines_o", lines_o, e.lines[4:0]);
                check("score_o", score_o, e.score[SW-1:0]);
            end
        end
    end

    task automatic run_op(input grid_t g, input bit repulse);
        exp_t e;
        int   n;
        int   lat;
        bit   seen;
        model(g, e.grid, e.lines);
        model_score = model_score + pts(e.lines);
        if (model_score > SMAX) model_score = SMAX;
        e.score = model_score;
        exp_q.push_back(e);
        grid_i  = g;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        grid_i  = ~g;
        n = 0; lat = -1; seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (done_o) begin
                seen = 1'b1;
                lat  = c;
            end else begin
                if (busy_o) n++;
                start_i = repulse && (c == 5);
                if (repulse && c == 5) grid_i = grid_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
                @(negedge clk);
            end
        end
        start_i = 1'b0;
        if (!seen) check("done_timeout", 1'b0, 1'b1);
        else begin
            ops_done++;
            check("busy_cycles", n, 23);
            check("done_latency", lat, 23);
        end
        @(negedge clk);
        check("done_one_cycle", done_o, 1'b0);
    endtask

    function automatic grid_t rand_grid();
        grid_t g;
        int    top;
        g   = '0;
        top = $urandom_range(ROWS-1, 0);
        for (int r = top; r < ROWS; r++) begin
            if ($urandom_range(2, 0) == 0) g[r] = '1;
            else begin
                g[r] = COLS'($urandom);
                if (g[r] == {COLS{1'b1}}) g[r][$urandom_range(COLS-1, 0)] = 1'b0;
            end
        end
        return g;
    endfunction

    initial begin
        grid_t g;
        int    dn;

        #2;
        check("rst_grid", grid_o, '0);
        check("rst_lines", lines_o, 0);
        check("rst_score", score_o, 0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Three full rows scores 300, then reset mid-scan aborts everything
        g = '0; g[19] = '1; g[20] = '1; g[21] = '1; g[18] = 10'h0AA;
        run_op(g, 1'b0);
        grid_i  = rand_grid();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_grid", grid_o, '0);
        check("abort_lines", lines_o, 0);
        check("abort_score", score_o, 0);
        check("abort_busy", busy_o, 1'b0);
        check("abort_done", done_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_score = 0;
        dn = done_seen;
        repeat (30) @(negedge clk);
        check("abort_no_done", done_seen, dn);
        check("abort_idle", busy_o, 1'b0);

        // Directed cases
        run_op('0, 1'b0);
        g = '0; g[21] = 10'h3FF; g[20] = 10'h201;
        run_op(g, 1'b0);
        g = '0; for (int r = 18; r < 22; r++) g[r] = '1; g[17] = 10'h0F0;
        run_op(g, 1'b0);
        run_op(g, 1'b0);
        g = '0; for (int r = 0; r < ROWS; r++) g[r] = r[0] ? 10'h3FF : 10'h155;
        run_op(g, 1'b0);
        g = '1;
        run_op(g, 1'b0);
        run_op(rand_grid(), 1'b1);

        for (int i = 0; i < 30; i++) run_op(rand_grid(), ($urandom_range(3, 0) == 0));

        // Drive the score into saturation with repeated tetrises
        g = '0; for (int r = 18; r < 22; r++) g[r] = '1;
        while (model_score < SMAX) run_op(g, 1'b0);
        run_op(g, 1'b0);
        check("score_saturated", score_o, SMAX[SW-1:0]);

        repeat (3) @(negedge clk);
        check("done_count", done_seen, ops_done);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
